alu_nibble_serial: RTL and testbench

ALU_NIBBLE_SERIAL -- requirements
Module: alu_nibble_serial

---
 rtl/alu_nibble_serial.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_alu_nibble_serial.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_nibble_serial.sv
// alu_nibble_serial -- nibble-serial ALU with a small internal register file.
//
// An accepted request latches its operands and then processes one 4-bit
// digit per enabled clock, so an operation takes WIDTH/4 enabled cycles.
// ROR walks the operand from the most-significant nibble down; every other
// operation walks up from the least-significant nibble. The carry register
// threads the digit carry (ADC/BCD) or the shifted-out bit (ROL/ROR)
// between nibbles and is seeded with CI.
//
// Parameters
//   WIDTH  operand / register width, multiple of 4, 8..32
//   NREG   number of internal registers, 2..8
//
// Ports
//   clk     clock, all state on the rising edge
//   reset   synchronous active-high reset (clears registers, aborts RUN)
//   RDY     global enable; low freezes every state element including done
//   start   request, taken when RDY=1 and the unit is idle
//   op      0 LDM, 1 ROL, 2 ROR, 3 ORA, 4 AND, 5 EOR, 6 ADC, 7 BCD
//   mode    0 add, 1 subtract (inverts mem for ADC/BCD only)
//   ra, rd  A-operand / destination register index
//   ld      write the result to reg[rd] on completion
//   mem     B operand
//   CI      carry in / shifted-in bit
//   busy    operation in progress
//   done    one enabled cycle after completion
//   result  last completed result
//   CO,N,Z,V flags of the last completed operation

module alu_nibble_serial #(
  parameter int WIDTH = 8,
  parameter int NREG  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    RDY,
  input  logic                    start,
  input  logic [2:0]              op,
  input  logic                    mode,
  input  logic [$clog2(NREG)-1:0] ra,
  input  logic [$clog2(NREG)-1:0] rd,
  input  logic                    ld,
  input  logic [WIDTH-1:0]        mem,
  input  logic                    CI,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH-1:0]        result,
  output logic                    CO,
  output logic                    N,
  output logic                    Z,
  output logic                    V
);

  localparam int NDIG  = WIDTH / 4;
  localparam int RW    = $clog2(NREG);
  localparam int CW    = $clog2(NDIG);
  localparam int NVIEW = 1 << RW;

  localparam logic [2:0] OP_LDM = 3'd0;
  localparam logic [2:0] OP_ROL = 3'd1;
  localparam logic [2:0] OP_ROR = 3'd2;
  localparam logic [2:0] OP_ORA = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_EOR = 3'd5;
  localparam logic [2:0] OP_ADC = 3'd6;
  localparam logic [2:0] OP_BCD = 3'd7;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_reg, state_next;
  logic              accept, finish;

  logic [CW-1:0]     cnt_reg;
  logic [WIDTH-1:0]  a_reg, b_reg, work_reg;
  logic [2:0]        op_reg;
  logic              mode_reg, ld_reg, carry_reg;
  logic [RW-1:0]     rd_reg;

  logic              done_reg, co_reg, n_reg, z_reg, v_reg;
  logic [WIDTH-1:0]  result_reg;

  logic [WIDTH-1:0]  reg_file [NREG];
  logic [WIDTH-1:0]  reg_view [NVIEW];

  logic [CW-1:0]     idx;
  logic [3:0]        a_slice [NDIG];
  logic [3:0]        b_slice [NDIG];
  logic [3:0]        a_nib, b_nib, dig;
  logic [4:0]        sum;
  logic              dig_carry, dig_ovf;
  logic [WIDTH-1:0]  work_next;
  logic              last;

  // ------------------------------------------------------------------
  // Register file view padded to a power of two: indices >= NREG read 0.
  // ------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NVIEW; gi++) begin : g_view
      if (gi < NREG) begin : g_real
        assign reg_view[gi] = reg_file[gi];
      end else begin : g_pad
        assign reg_view[gi] = '0;
      end
    end

    for (gi = 0; gi < NDIG; gi++) begin : g_slice
      assign a_slice[gi] = a_reg[gi*4 +: 4];
      assign b_slice[gi] = b_reg[gi*4 +: 4];
    end
  endgenerate

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  assign last = (cnt_reg == CW'(NDIG - 1));

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (RDY && start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (RDY && last) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // ------------------------------------------------------------------
  // Nibble datapath
  // ------------------------------------------------------------------
  // ROR counts down from the top nibble so the shifted-out bit of each
  // nibble can feed the next lower one.
  assign idx = (op_reg == OP_ROR) ? (CW'(NDIG - 1) - cnt_reg) : cnt_reg;

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx == CW'(i)) begin
        a_nib = a_slice[i];
        b_nib = b_slice[i];
      end
    end
  end

  assign sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_reg};

  always_comb begin
    dig       = '0;
    dig_carry = 1'b0;
    dig_ovf   = 1'b0;
    case (op_reg)
      OP_LDM: dig = b_nib;
      OP_ORA: dig = a_nib | b_nib;
      OP_AND: dig = a_nib & b_nib;
      OP_EOR: dig = a_nib ^ b_nib;
      OP_ROL: begin
        dig       = {a_nib[2:0], carry_reg};
        dig_carry = a_nib[3];
      end
      OP_ROR: begin
        dig       = {carry_reg, a_nib[3:1]};
        dig_carry = a_nib[0];
      end
      OP_ADC: begin
        dig       = sum[3:0];
        dig_carry = sum[4];
      end
      OP_BCD: begin
        if (!mode_reg) begin
          if (sum > 5'd9) begin
            dig       = sum[3:0] + 4'd6;
            dig_carry = 1'b1;
          end else begin
            dig       = sum[3:0];
          end
        end else begin
          // The subtrahend arrives 15s-complemented per digit; no carry
          // means a borrow, which is corrected by adding 10.
          dig_carry = sum[4];
          dig       = sum[4] ? sum[3:0] : (sum[3:0] + 4'd10);
        end
      end
      default: dig = '0;
    endcase
    // Overflow is taken from the uncorrected binary nibble sum: carry into
    // bit 3 xor carry out of bit 3. Only the top nibble's value is kept.
    if (op_reg == OP_ADC || op_reg == OP_BCD)
      dig_ovf = (a_nib[3] ^ b_nib[3] ^ sum[3]) ^ sum[4];
  end

  always_comb begin
    work_next = work_reg;
    for (int i = 0; i < NDIG; i++) begin
      if (idx == CW'(i)) work_next[i*4 +: 4] = dig;
    end
  end

  // ------------------------------------------------------------------
  // Operand latch, progress and result registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      work_reg   <= '0;
      op_reg     <= OP_LDM;
      mode_reg   <= 1'b0;
      ld_reg     <= 1'b0;
      rd_reg     <= '0;
      carry_reg  <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
      co_reg     <= 1'b0;
      n_reg      <= 1'b0;
      z_reg      <= 1'b1;
      v_reg      <= 1'b0;
    end else if (RDY) begin
      done_reg <= finish;
      if (accept) begin
        op_reg    <= op;
        mode_reg  <= mode;
        rd_reg    <= rd;
        ld_reg    <= ld;
        carry_reg <= CI;
        a_reg     <= reg_view[ra];
        b_reg     <= (mode && op[2] && op[1]) ? ~mem : mem;
        cnt_reg   <= '0;
        work_reg  <= '0;
      end else if (state_reg == RUN) begin
        carry_reg <= dig_carry;
        work_reg  <= work_next;
        cnt_reg   <= finish ? '0 : (cnt_reg + CW'(1));
        if (finish) begin
          result_reg <= work_next;
          co_reg     <= dig_carry;
          v_reg      <= dig_ovf;
          n_reg      <= work_next[WIDTH-1];
          z_reg      <= (work_next == '0);
        end
      end
    end
  end

  // The A operand was captured at accept, so writing back to the source
  // register on the final nibble is safe.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (reset)
        reg_file[i] <= '0;
      else if (finish && ld_reg && (rd_reg == RW'(i)))
        reg_file[i] <= work_next;
    end
  end

  assign busy   = (state_reg == RUN);
  assign done   = done_reg;
  assign result = result_reg;
  assign CO     = co_reg;
  assign N      = n_reg;
  assign Z      = z_reg;
  assign V      = v_reg;

endmodule

// File: tb/tb_alu_nibble_serial.sv
// Scoreboard bench for alu_nibble_serial at WIDTH=16, NREG=3.
// Expected results come from a word-level model and a register-file
// shadow; a monitor pops the scoreboard on every rising done.

module tb_alu_nibble_serial;

  localparam int WIDTH = 16;
  localparam int NREG  = 3;
  localparam int NDIG  = WIDTH / 4;

  logic              clk = 1'b0;
  logic              reset, RDY, start, mode, ld, CI;
  logic [2:0]        op;
  logic [1:0]        ra, rd;
  logic [WIDTH-1:0]  mem;
  logic              busy, done, CO, N, Z, V;
  logic [WIDTH-1:0]  result;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [15:0] res;
    logic        co;
    logic        n;
    logic        z;
    logic        v;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model_reg [4];
  logic        done_q = 1'b0;

  always #5 clk = ~clk;

  alu_nibble_serial #(.WIDTH(WIDTH), .NREG(NREG)) dut (
    .clk(clk), .reset(reset), .RDY(RDY), .start(start), .op(op), .mode(mode),
    .ra(ra), .rd(rd), .ld(ld), .mem(mem), .CI(CI),
    .busy(busy), .done(done), .result(result),
    .CO(CO), .N(N), .Z(Z), .V(V)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic md,
                                 input logic [15:0] a, input logic [15:0] m,
                                 input logic ci);
    exp_t        e;
    logic [15:0] b, r;
    logic [16:0] wide;
    logic        co, v;
    int          c, s, x, y, dg;
    b  = (md && o >= 3'd6) ? ~m : m;
    r  = '0;
    co = 1'b0;
    v  = 1'b0;
    case (o)
      3'd0: r = b;
      3'd1: begin r = {a[14:0], ci}; co = a[15]; end
      3'd2: begin r = {ci, a[15:1]}; co = a[0]; end
      3'd3: r = a | b;
      3'd4: r = a & b;
      3'd5: r = a ^ b;
      3'd6: begin
        wide = {1'b0, a} + {1'b0, b} + {16'h0000, ci};
        r    = wide[15:0];
        co   = wide[16];
        v    = (a[15] == b[15]) && (r[15] != a[15]);
      end
      default: begin
        c = ci ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
          x = (a >> (4*i)) & 15;
          y = (b >> (4*i)) & 15;
          s = x + y + c;
          if (i == 3)
            v = (((x >> 3) & 1) == ((y >> 3) & 1)) && (((s >> 3) & 1) != ((x >> 3) & 1));
          if (!md) begin
            if (s > 9) begin dg = (s + 6) % 16; c = 1; end
            else       begin dg = s;            c = 0; end
          end else begin
            c  = (s >= 16) ? 1 : 0;
            dg = (c == 1) ? (s % 16) : ((s + 10) % 16);
          end
          r[4*i +: 4] = dg[3:0];
        end
        co = (c == 1);
      end
    endcase
    e.res = r;
    e.co  = co;
    e.n   = r[15];
    e.z   = (r == 16'h0000);
    e.v   = v;
    return e;
  endfunction

  // Monitor: one scoreboard entry per rising done.
  exp_t mon_e;
  always @(negedge clk) begin
    if (!reset && done && !done_q) begin
      if (sb.size() == 0) begin
        check_val("sb_underflow", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        $display("txn: result=%h CO=%b N=%b Z=%b V=%b (exp %h %b %b %b %b)",
                 result, CO, N, Z, V, mon_e.res, mon_e.co, mon_e.n, mon_e.z, mon_e.v);
        check_val("result", result, mon_e.res);
        check_val("CO", CO, mon_e.co);
        check_val("N", N, mon_e.n);
        check_val("Z", Z, mon_e.z);
        check_val("V", V, mon_e.v);
      end
    end
    done_q = done;
  end

  // Issue one operation starting at the current negedge; returns at the
  // negedge where done is first seen high. stall>0 pokes start while busy
  // and then drops RDY for `stall` edges.
  task automatic run_op(input logic [2:0] o, input logic md, input logic [1:0] a_i,
                        input logic [1:0] d_i, input logic l, input logic [15:0] m,
                        input logic ci, input int stall);
    exp_t e;
    int   cycles;
    e = model(o, md, model_reg[a_i], m, ci);
    sb.push_back(e);
    if (l && d_i < 2'(NREG)) model_reg[d_i] = e.res;
    op = o; mode = md; ra = a_i; rd = d_i; ld = l; mem = m; CI = ci; start = 1'b1;
    @(negedge clk);
    // Scramble inputs to show the operands were latched at accept.
    start = 1'b0; op = ~o; mode = ~md; ra = ~a_i; rd = ~d_i; ld = ~l; mem = ~m; CI = ~ci;
    check_val("busy_acc", busy, 1'b1);
    cycles = 0;
    while (!done && cycles < 100) begin
      cycles++;
      if (stall > 0 && cycles == 1) start = 1'b1;
      if (stall > 0 && cycles == 2) begin start = 1'b0; RDY = 1'b0; end
      if (stall > 0 && cycles == 2 + stall) RDY = 1'b1;
      @(negedge clk);
    end
    RDY = 1'b1;
    start = 1'b0;
    check_val("latency", cycles, NDIG + stall);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) model_reg[i] = '0;
    reset = 1'b1; RDY = 1'b0; start = 1'b0; op = '0; mode = 1'b0;
    ra = '0; rd = '0; ld = 1'b0; mem = '0; CI = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    RDY = 1'b1;
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_result", result, 16'h0000);
    check_val("rst_CO", CO, 1'b0);
    check_val("rst_N", N, 1'b0);
    check_val("rst_Z", Z, 1'b1);
    check_val("rst_V", V, 1'b0);

    // BCD add with decimal carry ripple, written back to the source register.
    run_op(3'd0, 1'b0, 2'd0, 2'd0, 1'b1, 16'h0999, 1'b0, 0);
    run_op(3'd7, 1'b0, 2'd0, 2'd0, 1'b1, 16'h0001, 1'b0, 0);
    check_val("bcd_add_res", result, 16'h1000);
    run_op(3'd3, 1'b0, 2'd0, 2'd3, 1'b0, 16'h0000, 1'b0, 0);
    check_val("reg0_readback", result, 16'h1000);

    // BCD subtract 0 - 1 borrows through every digit.
    run_op(3'd0, 1'b0, 2'd0, 2'd1, 1'b1, 16'h0000, 1'b0, 0);
    run_op(3'd7, 1'b1, 2'd1, 2'd3, 1'b0, 16'h0001, 1'b1, 0);
    check_val("bcd_sub_res", result, 16'h9999);
    check_val("bcd_sub_CO", CO, 1'b0);

    // Signed overflow on ADC.
    run_op(3'd0, 1'b0, 2'd0, 2'd2, 1'b1, 16'h7FFF, 1'b0, 0);
    run_op(3'd6, 1'b0, 2'd2, 2'd3, 1'b0, 16'h0001, 1'b0, 0);
    check_val("adc_V", V, 1'b1);

    // ROR shifts CI into the top and bit 0 into CO.
    run_op(3'd0, 1'b0, 2'd0, 2'd0, 1'b1, 16'h0001, 1'b0, 0);
    run_op(3'd2, 1'b0, 2'd0, 2'd3, 1'b0, 16'h0000, 1'b1, 0);
    check_val("ror_res", result, 16'h8000);
    check_val("ror_CO", CO, 1'b1);

    run_op(3'd1, 1'b0, 2'd2, 2'd1, 1'b1, 16'h0000, 1'b1, 0);
    run_op(3'd6, 1'b1, 2'd2, 2'd2, 1'b1, 16'h0001, 1'b1, 0);
    run_op(3'd4, 1'b0, 2'd1, 2'd0, 1'b1, 16'hF0F0, 1'b0, 0);
    run_op(3'd5, 1'b0, 2'd0, 2'd3, 1'b1, 16'hFFFF, 1'b0, 0);

    // Stall of two cycles with an ignored start while busy.
    run_op(3'd6, 1'b0, 2'd2, 2'd1, 1'b1, 16'h1234, 1'b1, 2);
    @(negedge clk);
    check_val("stall_done_clr", done, 1'b0);
    check_val("stall_no_restart", busy, 1'b0);

    // Random traffic, sometimes back-to-back, sometimes with an idle gap.
    for (int n = 0; n < 24; n++) begin
      run_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 0);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        check_val("done_clr", done, 1'b0);
      end
    end

    // Reset in the second RUN cycle aborts the write-back.
    run_op(3'd0, 1'b0, 2'd0, 2'd1, 1'b1, 16'h1234, 1'b0, 0);
    op = 3'd6; mode = 1'b0; ra = 2'd1; rd = 2'd1; ld = 1'b1; mem = 16'h0001; CI = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("abort_busy", busy, 1'b0);
    check_val("abort_done", done, 1'b0);
    check_val("abort_Z", Z, 1'b1);
    check_val("abort_result", result, 16'h0000);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) model_reg[i] = '0;
    for (int i = 0; i < NDIG + 2; i++) begin
      @(negedge clk);
      check_val("abort_no_done", done, 1'b0);
    end
    run_op(3'd3, 1'b0, 2'd1, 2'd3, 1'b0, 16'h0000, 1'b0, 0);
    check_val("abort_reg1", result, 16'h0000);

    @(negedge clk);
    check_val("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
